// File: rtl/fetch_unit.sv
// Fetch unit: one outstanding imem request into a FIFO_DEPTH-entry decode buffer; an instruction is visible the cycle after its response.
// Requests stall while the buffer is full or a stale response is pending; `define FETCH_MISALIGN_TRAP_EN to halt on misaligned redirect targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] next_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        if_fault
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          pend_q, pend_d;
  logic          drop_q, drop_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q    [FIFO_DEPTH];
  logic [31:0]   instr_mem_q [FIFO_DEPTH];

  logic        accept;
  logic        resp_hit;
  logic        push;
  logic        pop;
  logic        misalign;
  logic [31:0] redir_pc;

  assign redir_pc = next_pc & 32'hFFFF_FFFC;

  assign imem_req_valid = (state_q == S_REQ) && (count_q < DEPTH_C) && !drop_q;
  assign imem_req_addr  = fetch_pc_q;

  assign accept   = imem_req_valid && imem_req_ready;
  assign resp_hit = pend_q && imem_resp_valid;
  // Redirect wins over push and pop: the buffer is flushed in the same cycle.
  assign push     = resp_hit && !drop_q && !redirect && (state_q == S_WAIT);
  assign pop      = if_valid && if_ready && !redirect;

  assign if_valid = (count_q != '0);
  assign if_instr = instr_mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    pend_d     = pend_q;
    drop_d     = drop_q;

    if (accept) begin
      pend_d     = 1'b1;
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_pc_d   = fetch_pc_q;
    end else if (resp_hit) begin
      pend_d = 1'b0;
      drop_d = 1'b0;
    end

    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   if (accept) state_d = S_WAIT;
      S_WAIT:  if (resp_hit) state_d = S_REQ;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // A request still in flight after a redirect has its response discarded;
    // repeated redirects only retarget, the single stale response is still dropped.
    if (redirect) begin
      drop_d = accept || (pend_q && !imem_resp_valid);
      if (misalign) begin
        state_d = S_HALT;
      end else begin
        fetch_pc_d = redir_pc;
        state_d    = drop_d ? S_WAIT : S_REQ;
      end
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      pend_q     <= 1'b0;
      drop_q     <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= req_pc_q;
        instr_mem_q[wr_ptr_q] <= imem_resp_data;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fault_q;
  logic [31:0] fault_pc_q;

  assign misalign = redirect && (next_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else if (redirect) begin
      fault_q <= misalign;
      if (misalign) fault_pc_q <= next_pc;
    end
  end

  assign if_fault = fault_q;
  assign if_pc    = fault_q ? fault_pc_q : pc_mem_q[rd_ptr_q];
`else
  assign misalign = 1'b0;
  assign if_fault = 1'b0;
  assign if_pc    = pc_mem_q[rd_ptr_q];
`endif

  // Only one request is ever outstanding and it is issued only with a free slot.
  a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a sequential-stream reference (expected decode PC and request PC) plus an in-order memory model.
module tb_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  localparam int M_RAND  = 0;
  localparam int M_OUT   = 1;
  localparam int M_PPP   = 2;
  localparam int M_NOW   = 3;
  localparam int M_RST   = 4;
  localparam int M_QUIET = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] next_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready = 1'b0;
  logic        if_fault;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .next_pc(next_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .if_ready(if_ready), .if_fault(if_fault)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // memory model: single in-order slot with a latency countdown
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  logic [31:0] exp_pc = RST_PC;
  logic [31:0] exp_req = RST_PC;
  logic [31:0] want_addr = '0;
  bit          prev_redir = 0;
  int          cyc = 0;
  int          first_valid = -1;
  int          pops = 0;
  int          rdy_pct = 100, ifr_pct = 100, redir_pct = 0, lat_min = 1, lat_max = 1;
`ifdef FETCH_MISALIGN_TRAP_EN
  bit          halted = 0;
  logic [31:0] fault_pc = '0;
`endif

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: sample at the falling edge, drive inputs, advance the model for the next rising edge.
  task automatic step(input int mode, input logic [31:0] tgt, output bit fired);
    bit          acc;
    logic [31:0] t;
    @(negedge clk);
    if (rst) begin
      cyc = 0;
      first_valid = -1;
    end else begin
      cyc++;
      if (first_valid < 0 && if_valid) first_valid = cyc;
      if (prev_redir) check_eq("flush_if_valid", 32'(if_valid), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check_eq("if_fault", 32'(if_fault), 32'(halted));
      if (halted) begin
        check_eq("halt_if_pc", if_pc, fault_pc);
        check_eq("halt_no_req", 32'(imem_req_valid), 32'd0);
      end
`else
      check_eq("if_fault_tied", 32'(if_fault), 32'd0);
`endif
    end

    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = instr_of(mem_addr);
        mem_busy = 0;
      end else begin
        mem_cnt--;
      end
    end

    imem_req_ready = ($urandom_range(99) < rdy_pct);
    if_ready       = ($urandom_range(99) < ifr_pct);
    rst            = (mode == M_RST);
    case (mode)
      M_RAND:  fired = ($urandom_range(99) < redir_pct);
      M_OUT:   fired = mem_busy && (mem_addr == want_addr);
      M_PPP:   fired = if_valid && if_ready && imem_resp_valid;
      M_NOW:   fired = 1;
      default: fired = 0;
    endcase
    redirect = fired;
    next_pc  = fired ? tgt : $urandom;

    if (rst) begin
      exp_pc = RST_PC;
      exp_req = RST_PC;
      prev_redir = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      halted = 0;
`endif
    end else begin
      acc = imem_req_valid && imem_req_ready;
      if (acc) begin
        check_eq("single_outstanding", 32'(mem_busy), 32'd0);
        check_eq("req_addr", imem_req_addr, exp_req);
        exp_req  = exp_req + 32'd4;
        mem_busy = 1;
        mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
        mem_addr = imem_req_addr;
      end
      if (fired) begin
        t = tgt & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
        halted = (tgt[1:0] != 2'b00);
        if (halted) fault_pc = tgt;
`endif
        exp_pc = t;
        exp_req = t;
        prev_redir = 1;
      end else begin
        prev_redir = 0;
        if (if_valid && if_ready) begin
          check_eq("if_pc", if_pc, exp_pc);
          check_eq("if_instr", if_instr, instr_of(exp_pc));
          exp_pc = exp_pc + 32'd4;
          pops++;
        end
      end
    end
  endtask

  task automatic run(input int mode, input int n);
    bit f;
    for (int i = 0; i < n; i++) step(mode, 32'h0, f);
  endtask

  task automatic set_knobs(input int rp, input int ip, input int lmin, input int lmax);
    rdy_pct = rp;
    ifr_pct = ip;
    lat_min = lmin;
    lat_max = lmax;
  endtask

  initial begin
    bit f;
    bit hit;
    int p0;

    run(M_RST, 3);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_req_addr", imem_req_addr, RST_PC);
    check_eq("rst_if_valid", 32'(if_valid), 32'd0);
    check_eq("rst_if_pc", if_pc, 32'd0);
    check_eq("rst_if_instr", if_instr, 32'd0);
    check_eq("rst_if_fault", 32'(if_fault), 32'd0);

    // back-to-back fetch from reset, 1-cycle memory
    set_knobs(100, 100, 1, 1);
    run(M_QUIET, 12);
    check_eq("first_valid_cycle", 32'(first_valid), 32'd3);
    check_eq("pops_after_boot", 32'(pops), 32'd5);

    // decode stalled: buffer fills to DEPTH then requests stop, nothing lost
    set_knobs(0, 100, 1, 1);
    run(M_QUIET, 5);
    set_knobs(100, 0, 1, 1);
    run(M_QUIET, 10);
    check_eq("full_no_req", 32'(imem_req_valid), 32'd0);
    p0 = pops;
    set_knobs(0, 100, 1, 1);
    run(M_QUIET, 6);
    check_eq("drained_count", 32'(pops - p0), 32'(DEPTH));

    // redirect while 0x8 is outstanding
    run(M_RST, 2);
    set_knobs(100, 100, 2, 2);
    want_addr = 32'h8;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(M_OUT, 32'h100, f);
      hit = f;
    end
    check_eq("redir_outstanding_fired", 32'(hit), 32'd1);
    p0 = pops;
    run(M_QUIET, 10);
    check_eq("redir_resume_pops", 32'(pops - p0 > 0), 32'd1);

    // redirect colliding with a pop and a push
    set_knobs(100, 40, 1, 1);
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      step(M_PPP, 32'h400, f);
      hit = f;
    end
    check_eq("redir_pop_push_fired", 32'(hit), 32'd1);
    run(M_QUIET, 8);

    // address wrap
    set_knobs(100, 100, 1, 1);
    step(M_NOW, 32'hFFFF_FFF8, f);
    run(M_QUIET, 12);

    // misaligned target
    step(M_NOW, 32'h0000_0102, f);
    run(M_QUIET, 8);
    step(M_NOW, 32'h0000_0200, f);
    run(M_QUIET, 8);

    // reset while a request is outstanding; the late response must be ignored
    set_knobs(100, 100, 2, 2);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(M_QUIET, 32'h0, f);
      hit = mem_busy && (mem_cnt == 1);
    end
    check_eq("wait_reached", 32'(hit), 32'd1);
    run(M_RST, 1);
    p0 = pops;
    run(M_QUIET, 12);
    check_eq("post_reset_pops", 32'(pops - p0 > 0), 32'd1);

    // random traffic
    set_knobs(70, 70, 1, 3);
    redir_pct = 4;
    for (int i = 0; i < 3000; i++) step(M_RAND, $urandom & 32'hFFFF_FFFC, f);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
